// File: rtl/bnn_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module   : bnn_neuron_array
//  Purpose  : Multi-neuron binary (XNOR-popcount) layer slice. Each accepted
//             input beat is XNORed against a per-neuron, per-beat weight word.
//             The matching bits are popcounted and accumulated over BEATS
//             beats. Each neuron then fires when its count reaches its
//             threshold.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous reset, active high (legacy name)
//    clr        in   synchronous abort of partial inference / pending result
//    in_valid   in   input beat valid
//    in_ready   out  block can accept a beat (state != DONE)
//    in_data    in   [IN_W] binarised activations (1 = +1, 0 = -1)
//    wt         in   [NUM_NEURONS*BEATS*IN_W] weights, neuron n / beat b at
//                    [(n*BEATS+b)*IN_W +: IN_W]
//    thr        in   [NUM_NEURONS*ACC_W] thresholds, neuron n at [n*ACC_W +: ACC_W]
//    out_valid  out  result valid
//    out_ready  in   downstream accepts result
//    out_bits   out  [NUM_NEURONS] bit n = neuron n fired
//    out_pop    out  [NUM_NEURONS*ACC_W] final popcount per neuron
// ============================================================================
module bnn_neuron_array #(
  parameter int IN_W        = 8,
  parameter int NUM_NEURONS = 4,
  parameter int BEATS       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_W-1:0]                  in_data,
  input  logic [NUM_NEURONS*BEATS*IN_W-1:0] wt,
  input  logic [NUM_NEURONS*$clog2(IN_W*BEATS+1)-1:0] thr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_NEURONS-1:0]           out_bits,
  output logic [NUM_NEURONS*$clog2(IN_W*BEATS+1)-1:0] out_pop
);

  // Accumulator width holds the maximum possible count IN_W*BEATS.
  localparam int ACC_W = $clog2(IN_W*BEATS+1);
  // Beat counter width; at least one bit even for BEATS == 1.
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS-1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [BW-1:0]                  beat_q, beat_d;
  logic [NUM_NEURONS*ACC_W-1:0]   acc_q, acc_d;
  logic                           out_valid_q, out_valid_d;
  logic [NUM_NEURONS-1:0]         out_bits_q, out_bits_d;
  logic [NUM_NEURONS*ACC_W-1:0]   out_pop_q, out_pop_d;

  // Running count including the beat currently on in_data, and the
  // corresponding fire decision; both are only meaningful on an accept.
  logic [NUM_NEURONS*ACC_W-1:0]   beat_sum;
  logic [NUM_NEURONS-1:0]         beat_fire;
  logic                           accept;

  function automatic logic [ACC_W-1:0] popcnt(input logic [IN_W-1:0] v);
    logic [ACC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < IN_W; i++) begin
      cnt = cnt + ACC_W'(v[i]);
    end
    return cnt;
  endfunction

  generate
    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
      logic [IN_W-1:0]  word;
      logic [ACC_W-1:0] match_cnt;
      logic [ACC_W-1:0] sum;

      // Weight word for this neuron at the current beat position.
      assign word      = wt[(n*BEATS + int'(beat_q))*IN_W +: IN_W];
      assign match_cnt = popcnt(~(in_data ^ word));
      // Beat 0 overwrites the accumulator so no clear cycle is needed
      // between inferences.
      assign sum       = (beat_q == '0) ? match_cnt
                                        : acc_q[n*ACC_W +: ACC_W] + match_cnt;

      assign beat_sum[n*ACC_W +: ACC_W] = sum;
      assign beat_fire[n]               = (sum >= thr[n*ACC_W +: ACC_W]);
    end
  endgenerate

  assign in_ready = (state_q != S_DONE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_bits_d  = out_bits_q;
    out_pop_d   = out_pop_q;

    if (clr) begin
      // Abort wins over any beat or handshake in the same cycle.
      state_d     = S_IDLE;
      beat_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            acc_d = beat_sum;
            if (beat_q == LAST_BEAT) begin
              out_pop_d   = beat_sum;
              out_bits_d  = beat_fire;
              out_valid_d = 1'b1;
              state_d     = S_DONE;
              beat_d      = '0;
            end else begin
              beat_d  = beat_q + BW'(1);
              state_d = S_ACCUM;
            end
          end
        end
        S_DONE: begin
          // Result fields are left intact after the handshake.
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          beat_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_pop_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      out_pop_q   <= out_pop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;
  assign out_pop   = out_pop_q;

endmodule
`default_nettype wire

// File: doc/bnn_neuron_array.md
Name: bnn_neuron_array

Overview:
Parametrised multi-neuron binary (XNOR-popcount) layer slice. Each accepted input beat is XNORed against a per-neuron, per-beat weight word. The matching bits are popcounted and accumulated over BEATS beats. Each neuron then fires when its count reaches its threshold. Sits between the binarised feature stream and the next BNN layer, with valid/ready handshakes on both sides.

Parameters:
IN_W, 8, bits per input beat
NUM_NEURONS, 4, neurons evaluated in parallel
BEATS, 4, input beats per inference
ACC_W, $clog2(IN_W*BEATS+1), derived localparam, accumulator and threshold width (not overridable)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset
clr  in  1  synchronous abort: discard partial inference or pending result
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_data  in  IN_W  binarised activations (1 = +1, 0 = -1)
wt  in  NUM_NEURONS*BEATS*IN_W  weights; word for neuron n, beat b at bits [(n*BEATS+b)*IN_W +: IN_W]; static during an inference
thr  in  NUM_NEURONS*ACC_W  per-neuron threshold; neuron n at [n*ACC_W +: ACC_W]; static during an inference
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_bits  out  NUM_NEURONS  bit n = neuron n fired
out_pop  out  NUM_NEURONS*ACC_W  final popcount per neuron, same packing as thr

Behaviour:
- Reset rst_n: asynchronous, active-high. Clock clk.
- Reset values: state IDLE; beat counter 0; all accumulators 0; out_valid 0; out_bits 0; out_pop 0; in_ready 1 once reset deasserts.
- FSM states: IDLE, ACCUM, DONE. in_ready = (state != DONE), derived combinationally from state.
- Beat accept: in_valid & in_ready at a rising edge.
- Per accepted beat b: p[n] = popcount(~(in_data ^ wt[n][b])), range 0..IN_W.
- Beat 0 loads acc[n] = p[n] (overwrite, no separate clear cycle). Beats 1..BEATS-1 add: acc[n] = acc[n] + p[n].
- ACC_W is sized so the accumulator never overflows. The maximum sum is IN_W*BEATS.
- IDLE: an accepted beat moves to ACCUM with beat counter 1. If BEATS==1, it goes straight to DONE.
- ACCUM: beats with in_valid low are stalls, with no state change.
- On the accepted beat BEATS-1, at the same edge:
  - out_pop[n] <= acc[n] + p[n]
  - out_bits[n] <= ((acc[n] + p[n]) >= thr[n]), unsigned compare
  - out_valid <= 1
  - state <= DONE
  - beat counter <= 0
- Latency: out_valid rises the cycle after the last beat is accepted.
- DONE: out_valid, out_bits and out_pop hold stable until out_valid & out_ready. in_ready is 0, so in_valid is ignored. On the handshake edge: out_valid <= 0, state <= IDLE.
- Throughput: BEATS+1 cycles per inference with no stalls.
- out_bits and out_pop are not cleared on handshake. They keep their last values while out_valid is 0.
- Threshold boundaries: thr[n]==0 always fires. thr[n] > IN_W*BEATS never fires. A count exactly equal to thr[n] fires.
- clr (synchronous) has priority over every other event in the same cycle:
  - state <= IDLE, beat counter <= 0, out_valid <= 0
  - a beat presented in that cycle is not accumulated
  - a pending result is dropped, even if out_ready is high that cycle
- Reset mid-operation: everything returns to reset values immediately. The partial inference is lost.
- Weights and thresholds are sampled live on every beat. Changing them mid-inference is a user error, with no protection.

Test Plan:
1. IN_W=8, BEATS=4. wt n0 all 0xFF; in_data 0xFF x4; thr0=32, thr1=33 with n1 weights also 0xFF -> out_bits[0]=1, out_bits[1]=0, out_pop n0=n1=32, out_valid 1 cycle after 4th beat.
2. in_data 0x0F x4, wt n0 all 0xF0, wt n2 all 0x0F; thr0=0, thr2=17 -> n0 pop 0 fires; n2 pop 32 fires; thr2=33 -> n2 0.
3. Backpressure: complete an inference, hold out_ready=0 for 5 cycles while driving in_valid=1 -> out_valid/out_bits stable, in_ready=0, no beats consumed; out_ready=1 -> out_valid drops next cycle, in_ready=1.
4. Stalls and back-to-back: beats with 1-3 idle cycles between, then a second inference with different data -> first result equals the gap-free result; second out_pop independent of first (beat-0 overwrite verified).
5. clr after 2 beats, then 4 fresh beats -> result reflects only the fresh beats. clr while DONE with out_ready=1 -> no handshake counted, out_valid 0, state IDLE.
6. rst_n pulsed mid-ACCUM (after beat 2) and while DONE -> out_valid 0, out_bits/out_pop 0 asynchronously; next full inference correct.
